// File: rtl/cpu_player_if.sv
// Move interface between the automatic player and the game controller.
// The controller side (or a bench) uses the master modport. The player uses the slave modport.
interface cpu_player_if;
   logic        moveReq;
   logic [1:0]  mySymbol;
   logic [17:0] gBoard;
   logic        gameIsDone;
   logic        playerWrite;
   logic [3:0]  playerInput;
   logic        busy;
   logic        noMove;

   modport master (
      output moveReq, mySymbol, gBoard, gameIsDone,
      input  playerWrite, playerInput, busy, noMove
   );

   modport slave (
      input  moveReq, mySymbol, gBoard, gameIsDone,
      output playerWrite, playerInput, busy, noMove
   );
endinterface

// File: rtl/cpu_player.sv
// Automatic tic-tac-toe opponent.
// On a request it snapshots the board and scans for a move in this order:
// win a line, block the opponent's line, take the center, take a corner, take an edge.
// The chosen cell is then presented with a one-cycle strobe.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for moveReq; all outputs low
// S_WIN    | one line per cycle: two own cells plus one empty cell
// S_BLOCK  | one line per cycle: two opponent cells plus one empty cell
// S_STATIC | center, then corners, then edges; no empty cell -> NOMOVE
// S_ISSUE  | playerWrite strobe with the latched cell
// S_NOMOVE | noMove pulse; the snapshot has no empty cell
module cpu_player (
   input logic         ph1,
   input logic         reset,
   cpu_player_if.slave mv
);

   typedef enum logic [2:0] {
      S_IDLE, S_WIN, S_BLOCK, S_STATIC, S_ISSUE, S_NOMOVE
   } state_t;

   state_t      state_q, state_d;
   logic [17:0] board_q, board_d;
   logic [1:0]  sym_q, sym_d;
   logic [2:0]  line_idx_q, line_idx_d;
   logic [3:0]  cell_q, cell_d;
   logic        player_write_q, player_write_d;
   logic [3:0]  player_input_q, player_input_d;
   logic        busy_q, busy_d;
   logic        no_move_q, no_move_d;

   logic [3:0]  la, lb, lc;
   logic [1:0]  va, vb, vc, tgt;
   logic        line_hit, static_hit;
   logic [3:0]  line_cell, static_cell;
   logic [8:0]  empty;

   function automatic logic [1:0] cell_code(input logic [17:0] b, input logic [3:0] idx);
      return b[{idx, 1'b0} +: 2];
   endfunction

   function automatic logic [11:0] line_cells(input logic [2:0] k);
      case (k)
         3'd0:    return {4'd0, 4'd1, 4'd2};
         3'd1:    return {4'd3, 4'd4, 4'd5};
         3'd2:    return {4'd6, 4'd7, 4'd8};
         3'd3:    return {4'd0, 4'd3, 4'd6};
         3'd4:    return {4'd1, 4'd4, 4'd7};
         3'd5:    return {4'd2, 4'd5, 4'd8};
         3'd6:    return {4'd0, 4'd4, 4'd8};
         default: return {4'd2, 4'd4, 4'd6};
      endcase
   endfunction

   // Evaluate the current line for the WIN/BLOCK target, and the static center/corner/edge pick.
   always_comb begin
      {la, lb, lc} = line_cells(line_idx_q);
      va = cell_code(board_q, la);
      vb = cell_code(board_q, lb);
      vc = cell_code(board_q, lc);
      // The opponent code differs from the own code only in bit 0.
      tgt = (state_q == S_BLOCK) ? (sym_q ^ 2'b01) : sym_q;
      line_hit  = 1'b0;
      line_cell = 4'd0;
      if (va == tgt && vb == tgt && vc == 2'b00) begin
         line_hit  = 1'b1;
         line_cell = lc;
      end else if (va == tgt && vc == tgt && vb == 2'b00) begin
         line_hit  = 1'b1;
         line_cell = lb;
      end else if (vb == tgt && vc == tgt && va == 2'b00) begin
         line_hit  = 1'b1;
         line_cell = la;
      end

      for (int i = 0; i < 9; i++) begin
         empty[i] = (cell_code(board_q, 4'(i)) == 2'b00);
      end
      static_hit  = 1'b1;
      static_cell = 4'd0;
      if      (empty[4]) static_cell = 4'd4;
      else if (empty[0]) static_cell = 4'd0;
      else if (empty[2]) static_cell = 4'd2;
      else if (empty[6]) static_cell = 4'd6;
      else if (empty[8]) static_cell = 4'd8;
      else if (empty[1]) static_cell = 4'd1;
      else if (empty[3]) static_cell = 4'd3;
      else if (empty[5]) static_cell = 4'd5;
      else if (empty[7]) static_cell = 4'd7;
      else               static_hit  = 1'b0;
   end

   // Next-state logic and the next values of the registered Moore outputs.
   always_comb begin
      state_d    = state_q;
      board_d    = board_q;
      sym_d      = sym_q;
      line_idx_d = line_idx_q;
      cell_d     = cell_q;
      case (state_q)
         S_IDLE: begin
            // Both legal symbols (11 and 10) have bit 1 set.
            if (mv.moveReq && !mv.gameIsDone && mv.mySymbol[1]) begin
               board_d    = mv.gBoard;
               sym_d      = mv.mySymbol;
               line_idx_d = 3'd0;
               state_d    = S_WIN;
            end
         end
         S_WIN, S_BLOCK: begin
            if (mv.gameIsDone) begin
               state_d = S_IDLE;
            end else if (line_hit) begin
               cell_d  = line_cell;
               state_d = S_ISSUE;
            end else if (line_idx_q == 3'd7) begin
               line_idx_d = 3'd0;
               state_d    = (state_q == S_WIN) ? S_BLOCK : S_STATIC;
            end else begin
               line_idx_d = line_idx_q + 3'd1;
            end
         end
         S_STATIC: begin
            if (mv.gameIsDone) begin
               state_d = S_IDLE;
            end else if (static_hit) begin
               cell_d  = static_cell;
               state_d = S_ISSUE;
            end else begin
               state_d = S_NOMOVE;
            end
         end
         S_ISSUE, S_NOMOVE: state_d = S_IDLE;
         default:           state_d = S_IDLE;
      endcase

      // Decode the outputs from the next state so each output flop matches its state exactly.
      player_write_d = (state_d == S_ISSUE);
      player_input_d = (state_d == S_ISSUE) ? cell_d : 4'd0;
      busy_d         = (state_d != S_IDLE);
      no_move_d      = (state_d == S_NOMOVE);
   end

   // State, snapshot and output registers with asynchronous clear.
   always_ff @(posedge ph1 or posedge reset) begin
      if (reset) begin
         state_q        <= S_IDLE;
         board_q        <= 18'd0;
         sym_q          <= 2'b00;
         line_idx_q     <= 3'd0;
         cell_q         <= 4'd0;
         player_write_q <= 1'b0;
         player_input_q <= 4'd0;
         busy_q         <= 1'b0;
         no_move_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         board_q        <= board_d;
         sym_q          <= sym_d;
         line_idx_q     <= line_idx_d;
         cell_q         <= cell_d;
         player_write_q <= player_write_d;
         player_input_q <= player_input_d;
         busy_q         <= busy_d;
         no_move_q      <= no_move_d;
      end
   end

   assign mv.playerWrite = player_write_q;
   assign mv.playerInput = player_input_q;
   assign mv.busy        = busy_q;
   assign mv.noMove      = no_move_q;

endmodule
